// File: rtl/crc16_pkg.sv
// ----------------------------------------------------------------------------
// crc16_pkg
// Shared definitions for the CRC-16 serial checker and its matching encoder.
//   CRC16_POLY      : generator x^16+x^15+x^2+1 (implicit x^16 term omitted)
//   CRC16_INIT      : register preset applied at the start of every frame
//   CRC16_MIN_BITS  : shortest legal frame (1 data bit + 16 CRC bits)
//   ST_*            : checker FSM state encoding
// ----------------------------------------------------------------------------
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'h0000;
    localparam int          CRC16_MIN_BITS = 17;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

endpackage

// File: rtl/crc16_lfsr_step.sv
// ----------------------------------------------------------------------------
// crc16_lfsr_step
// Combinational single-bit CRC-16 register update (MSB-first, no reflection).
// The encoder uses the same block, so both sides always agree on bit order.
//   crc_cur  [15:0] in  : current register value
//   bit_in          in  : incoming serial bit
//   crc_next [15:0] out : register value after absorbing bit_in
// ----------------------------------------------------------------------------
module crc16_lfsr_step
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY
) (
    input  logic [15:0] crc_cur,
    input  logic        bit_in,
    output logic [15:0] crc_next
);

    logic fb;

    // Feedback is the bit that would be shifted out XOR the new bit;
    // when set, the polynomial is subtracted (XORed) from the shifted value.
    assign fb       = crc_cur[15] ^ bit_in;
    assign crc_next = {crc_cur[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

endmodule

// File: rtl/crc_16_serial_check.sv
// ----------------------------------------------------------------------------
// crc_16_serial_check
// Serial CRC-16 frame checker. A frame is data bits MSB-first followed by the
// 16 transmitted CRC bits MSB-first; a good frame leaves a zero remainder.
//   clk            in  : clock, rising edge
//   rst            in  : asynchronous active-low reset
//   load           in  : start of frame (presets register, opens frame)
//   bit_en         in  : crc_in carries a valid bit this cycle
//   crc_in         in  : serial received bit
//   d_finish       in  : last bit of frame (may coincide with last bit_en)
//   busy           out : high in RECV and CHECK
//   done           out : one-cycle pulse when the verdict is valid
//   crc_ok         out : frame passed, held until next load/reset
//   crc_err        out : frame failed, held until next load/reset
//   syndrome [15:0] out: live remainder register
//   bit_cnt  [15:0] out: bits accepted in the current frame (saturating)
// ----------------------------------------------------------------------------
module crc_16_serial_check
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY     = CRC16_POLY,
    parameter logic [15:0] INIT     = CRC16_INIT,
    parameter int          MIN_BITS = CRC16_MIN_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bit_en,
    input  logic        crc_in,
    input  logic        d_finish,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic [15:0] syndrome,
    output logic [15:0] bit_cnt
);

    localparam logic [15:0] MIN_BITS_W = 16'(MIN_BITS);

    logic [1:0]  state_reg,    state_next;
    logic [15:0] syndrome_reg, syndrome_next;
    logic [15:0] bit_cnt_reg,  bit_cnt_next;
    logic        done_reg,     done_next;
    logic        crc_ok_reg,   crc_ok_next;
    logic        crc_err_reg,  crc_err_next;
    logic [15:0] step_crc;
    logic        frame_good;

    crc16_lfsr_step #(
        .POLY (POLY)
    ) u_step (
        .crc_cur  (syndrome_reg),
        .bit_in   (crc_in),
        .crc_next (step_crc)
    );

    assign frame_good = (syndrome_reg == 16'h0000) && (bit_cnt_reg >= MIN_BITS_W);

    always_comb begin
        state_next    = state_reg;
        syndrome_next = syndrome_reg;
        bit_cnt_next  = bit_cnt_reg;
        done_next     = 1'b0;
        crc_ok_next   = crc_ok_reg;
        crc_err_next  = crc_err_reg;

        // load wins over everything, including a pending verdict in CHECK
        // and a same-cycle d_finish.
        if (load) begin
            state_next    = ST_RECV;
            syndrome_next = INIT;
            bit_cnt_next  = 16'h0000;
            crc_ok_next   = 1'b0;
            crc_err_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_RECV: begin
                    // A bit arriving with d_finish is absorbed before the verdict.
                    if (bit_en) begin
                        syndrome_next = step_crc;
                        if (bit_cnt_reg != 16'hFFFF) begin
                            bit_cnt_next = bit_cnt_reg + 16'h0001;
                        end
                    end
                    if (d_finish) begin
                        state_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    crc_ok_next  = frame_good;
                    crc_err_next = !frame_good;
                    done_next    = 1'b1;
                    state_next   = ST_IDLE;
                end
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            syndrome_reg <= INIT;
            bit_cnt_reg  <= 16'h0000;
            done_reg     <= 1'b0;
            crc_ok_reg   <= 1'b0;
            crc_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            syndrome_reg <= syndrome_next;
            bit_cnt_reg  <= bit_cnt_next;
            done_reg     <= done_next;
            crc_ok_reg   <= crc_ok_next;
            crc_err_reg  <= crc_err_next;
        end
    end

    assign busy     = (state_reg == ST_RECV) || (state_reg == ST_CHECK);
    assign done     = done_reg;
    assign crc_ok   = crc_ok_reg;
    assign crc_err  = crc_err_reg;
    assign syndrome = syndrome_reg;
    assign bit_cnt  = bit_cnt_reg;

endmodule

// File: tb/tb_crc_16_serial_check.sv
// ----------------------------------------------------------------------------
// tb_crc_16_serial_check
// Directed and randomized frames for crc_16_serial_check. Expected remainders
// come from textbook polynomial long division of the received bit string.
// ----------------------------------------------------------------------------
module tb_crc_16_serial_check;

    localparam logic [16:0] GEN = 17'h18005;  // x^16+x^15+x^2+1 with x^16 term

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        bit_en;
    logic        crc_in;
    logic        d_finish;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        crc_err;
    logic [15:0] syndrome;
    logic [15:0] bit_cnt;

    int vectors     = 0;
    int miscompares = 0;
    bit frame_q[$];

    crc_16_serial_check dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bit_en   (bit_en),
        .crc_in   (crc_in),
        .d_finish (d_finish),
        .busy     (busy),
        .done     (done),
        .crc_ok   (crc_ok),
        .crc_err  (crc_err),
        .syndrome (syndrome),
        .bit_cnt  (bit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remainder of B(x)*x^16 mod G(x) over GF(2), B = frame_q read MSB-first.
    function automatic logic [15:0] ref_rem();
        bit d[$];
        logic [15:0] r;
        int n;
        d = frame_q;
        n = d.size();
        for (int k = 0; k < 16; k++) d.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (d[i]) begin
                for (int j = 0; j <= 16; j++) d[i+j] = d[i+j] ^ GEN[16-j];
            end
        end
        for (int k = 0; k < 16; k++) r[15-k] = d[n+k];
        return r;
    endfunction

    task automatic build_golden();
        string s;
        logic [7:0]  b;
        logic [15:0] c;
        s = "123456789";
        c = 16'hFEE8;
        frame_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            for (int k = 7; k >= 0; k--) frame_q.push_back(b[k]);
        end
        for (int k = 15; k >= 0; k--) frame_q.push_back(c[k]);
    endtask

    // Send frame_q as one frame and check the verdict sequence.
    task automatic run_frame(input string tag, input int gap_every, input int gap_len,
                             input bit finish_separate);
        int n;
        logic [15:0] exp_rem;
        bit exp_ok;
        n       = frame_q.size();
        exp_rem = ref_rem();
        exp_ok  = (exp_rem == 16'h0000) && (n >= 17);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk({tag, ":load_busy"}, busy, 1);
        chk({tag, ":load_cnt"}, bit_cnt, 0);
        for (int i = 0; i < n; i++) begin
            bit_en   = 1'b1;
            crc_in   = frame_q[i];
            d_finish = !finish_separate && (i == n - 1);
            tick();
            bit_en   = 1'b0;
            d_finish = 1'b0;
            if (gap_every > 0 && ((i + 1) % gap_every) == 0 && i != n - 1)
                repeat (gap_len) tick();
        end
        if (finish_separate) begin
            d_finish = 1'b1;
            tick();
            d_finish = 1'b0;
        end
        chk({tag, ":check_done"}, done, 0);
        chk({tag, ":check_busy"}, busy, 1);
        chk({tag, ":syndrome"}, syndrome, exp_rem);
        chk({tag, ":bit_cnt"}, bit_cnt, n);
        tick();
        chk({tag, ":done"}, done, 1);
        chk({tag, ":crc_ok"}, crc_ok, exp_ok);
        chk({tag, ":crc_err"}, crc_err, !exp_ok);
        chk({tag, ":busy_idle"}, busy, 0);
        tick();
        chk({tag, ":done_drop"}, done, 0);
        chk({tag, ":ok_held"}, crc_ok, exp_ok);
        chk({tag, ":not_both"}, crc_ok & crc_err, 0);
        $display("frame %s: %0d bits rem=%04h ok=%0b", tag, n, exp_rem, exp_ok);
    endtask

    initial begin
        int          dlen;
        int          idx;
        logic [15:0] rem;

        rst = 1'b0; load = 1'b0; bit_en = 1'b0; crc_in = 1'b0; d_finish = 1'b0;
        #12;
        chk("reset:busy", busy, 0);
        chk("reset:done", done, 0);
        chk("reset:ok", crc_ok, 0);
        chk("reset:err", crc_err, 0);
        chk("reset:syndrome", syndrome, 0);
        chk("reset:bit_cnt", bit_cnt, 0);
        tick();
        rst = 1'b1;

        // Golden frame, d_finish on the last CRC bit
        build_golden();
        run_frame("golden", 0, 0, 0);
        chk("golden:syn_zero", syndrome, 16'h0000);
        chk("golden:cnt88", bit_cnt, 88);

        // bit_en/d_finish in IDLE must be ignored
        bit_en = 1'b1; crc_in = 1'b1; d_finish = 1'b1;
        repeat (4) tick();
        bit_en = 1'b0; crc_in = 1'b0; d_finish = 1'b0;
        chk("idle:syndrome", syndrome, 0);
        chk("idle:bit_cnt", bit_cnt, 88);
        chk("idle:ok", crc_ok, 1);
        chk("idle:done", done, 0);
        chk("idle:busy", busy, 0);

        // Corrupt frame: bit 5 inverted
        build_golden();
        frame_q[5] = !frame_q[5];
        run_frame("corrupt", 0, 0, 0);
        chk("corrupt:syn_nz", syndrome != 16'h0000, 1);
        chk("corrupt:err", crc_err, 1);

        // Gapped golden frame: 3 idle cycles every 8 bits
        build_golden();
        run_frame("gapped", 8, 3, 0);
        chk("gapped:ok", crc_ok, 1);
        chk("gapped:cnt88", bit_cnt, 88);

        // Short frame: 16 zero bits, d_finish on its own cycle
        frame_q.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back(1'b0);
        run_frame("short", 0, 0, 1);
        chk("short:syn_zero", syndrome, 0);
        chk("short:err", crc_err, 1);

        // Reset at bit 40 of the golden frame
        build_golden();
        load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bit_en = 1'b1; crc_in = frame_q[i]; tick();
        end
        bit_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid:busy", busy, 0);
        chk("rst_mid:syndrome", syndrome, 0);
        chk("rst_mid:bit_cnt", bit_cnt, 0);
        chk("rst_mid:ok_err", {crc_ok, crc_err}, 0);
        repeat (2) begin
            tick();
            chk("rst_mid:no_done", done, 0);
        end
        rst = 1'b1;
        run_frame("after_rst", 0, 0, 0);

        // load together with d_finish: restart, no verdict
        build_golden();
        load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_en = 1'b1; crc_in = frame_q[i]; tick();
        end
        load = 1'b1; d_finish = 1'b1; bit_en = 1'b1; crc_in = 1'b1;
        tick();
        load = 1'b0; d_finish = 1'b0; bit_en = 1'b0;
        chk("load_fin:cnt", bit_cnt, 0);
        chk("load_fin:syn", syndrome, 0);
        chk("load_fin:busy", busy, 1);
        repeat (3) begin
            tick();
            chk("load_fin:no_done", done, 0);
        end
        chk("load_fin:still_recv", busy, 1);

        // load during CHECK aborts the verdict
        load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < frame_q.size(); i++) begin
            bit_en = 1'b1; crc_in = frame_q[i];
            d_finish = (i == frame_q.size() - 1);
            tick();
        end
        bit_en = 1'b0; d_finish = 1'b0;
        load = 1'b1; tick(); load = 1'b0;
        chk("abort_check:done", done, 0);
        chk("abort_check:busy", busy, 1);
        chk("abort_check:cnt", bit_cnt, 0);
        chk("abort_check:ok", crc_ok, 0);
        tick();
        chk("abort_check:done2", done, 0);

        // Randomized frames: random data + model CRC, sometimes corrupted
        for (int f = 0; f < 25; f++) begin
            frame_q.delete();
            dlen = $urandom_range(0, 40);
            for (int i = 0; i < dlen; i++) frame_q.push_back(1'($urandom_range(0, 1)));
            rem = ref_rem();
            for (int k = 15; k >= 0; k--) frame_q.push_back(rem[k]);
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, frame_q.size() - 1);
                frame_q[idx] = !frame_q[idx];
            end
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 5),
                      $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
